uart_word_packer: RTL and testbench
===================================

Name: uart_word_packer

Overview:
- Sits between the byte-level UART receiver and the FIR filter core.
- Collects four received bytes into one 32-bit IEEE-754 word and presents it on a valid/ready handshake, with a one-word output holding register.
- Discards partial words after an inter-byte timeout; flags words lost to back-pressure.
- Replaces the ad-hoc byte-counting flags in the UART/FIR top level.

Parameters:
- CLK_FRE, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate.
- TIMEOUT_BYTES, 4, inter-byte silence that aborts a partial word, in byte times; 1 byte time = 10*(CLK_FRE/BAUD_RATE) cycles.
- MSB_FIRST, 1, 1: first byte goes to word_data[31:24]; 0: first byte goes to [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; same effect as reset; highest synchronous priority.
- rx_valid  in  1  one-cycle strobe; rx_data valid in the same cycle. The top level delays the receiver's done strobe by one cycle to meet this.
- rx_data  in  8  received byte.
- word_valid  out  1  output register holds an untransferred word.
- word_ready  in  1  consumer (FIR start logic) accepts the word.
- word_data  out  32  assembled word; stable while word_valid=1.
- byte_cnt  out  3  bytes in the partial word (0..4; 4 only when CHECKSUM_EN waits for the checksum byte).
- busy  out  1  byte_cnt!=0 or word_valid=1.
- timeout_err  out  1  one-cycle pulse when a partial word is discarded by timeout.
- overrun_err  out  1  sticky; set when a completed word is dropped; cleared only by rst/clr.
- chk_err  out  1  one-cycle pulse on checksum mismatch; constant 0 without CHECKSUM_EN.

Behaviour:
- Reset/clr: word_valid=0, word_data=0, byte_cnt=0, busy=0, all error outputs=0, timeout counter=0, assembly register=0.
- Assembly FSM states:
  - IDLE (byte_cnt=0): first rx_valid → COLLECT, byte_cnt=1.
  - COLLECT: each rx_valid shifts the byte in at the position given by MSB_FIRST and increments byte_cnt.
  - The 4th byte completes the word; the FSM returns to IDLE in the same cycle.
- Output register:
  - On completion it loads if empty, or if a transfer (word_valid&&word_ready) happens in that same cycle.
  - Otherwise the new word is dropped, overrun_err is set, and the held word is unchanged.
- Latency: word_valid rises the cycle after the rx_valid of the completing byte; word_data is updated in that same cycle.
- Handshake:
  - Transfer when word_valid&&word_ready at a rising edge; word_valid then drops unless a new word loads in the same cycle.
  - word_valid never drops without a transfer.
  - word_ready is ignored while word_valid=0.
- Timeout:
  - The counter runs only while byte_cnt!=0 and clears on every rx_valid.
  - When it reaches TIMEOUT_BYTES*10*(CLK_FRE/BAUD_RATE)-1: byte_cnt→0, timeout_err pulses, the assembly register clears.
  - Default limit: 4*10*434 = 17360 cycles.
  - The counter is 32 bits wide.
- Simultaneous events:
  - Timeout and rx_valid in the same cycle: the partial word is discarded, timeout_err pulses, and the byte starts a new word (byte_cnt=1).
  - clr with any event: clr wins.
- Reset mid-word: the partial word is lost with no error pulse.
- The output register is not affected by timeout.
- No arithmetic on the data: bytes are concatenated only, and the bit pattern is preserved.

Optional Feature:
- CHECKSUM_EN
- Defined:
  - A 5th byte is expected after the four data bytes; it equals the XOR of the four.
  - byte_cnt reaches 4 while waiting for it.
  - Match: the word proceeds to the output register as above, so latency is measured from the checksum byte.
  - Mismatch: the word is discarded, chk_err pulses, and overrun logic is not evaluated.
  - The timeout also applies while waiting for the checksum byte.
- Undefined: 4-byte frames; chk_err tied to 0; no checksum logic synthesised.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef (IDLE, COLLECT).
  - Byte-time constant function CLK_FRE/BAUD_RATE*10.
  - WORD_BYTES=4.
  - Checksum byte count.
- One sub-module, uart_timeout_cnt: loadable down-counter with clear and expire pulse.
- Byte shift, FSM and output register stay in the top module.

Test Plan:
- Bytes 0x3F,0x80,0x00,0x00 (MSB_FIRST=1), word_ready=1 → word_data=0x3F800000, word_valid high exactly 1 cycle, starting the cycle after the 4th strobe.
- word_ready=0; send 0x40490FDB, then a second word 0x3F000000 → first word held; overrun_err=1 after the 8th byte; after word_ready=1, word_data=0x40490FDB.
- Send 2 bytes, then 17360 idle cycles → timeout_err pulse; byte_cnt=0. Then send 0xC0,0x00,0x00,0x00 → word_data=0xC0000000, no overrun.
- Held word with word_ready asserted in the same cycle the next word completes → back-to-back transfer; overrun_err stays 0.
- Assert rst after 3 bytes → all outputs 0. The next 4 bytes 0x11,0x22,0x33,0x44 → 0x11223344 (0x44332211 with MSB_FIRST=0).
- CHECKSUM_EN: 0x3F,0x80,0x00,0x00,0xBF → word accepted. Checksum byte 0x00 → chk_err pulse; word_valid stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART receive-side word packer.
//   asm_state_t : assembly FSM state (IDLE, COLLECT)
//   WORD_BYTES  : data bytes per assembled word
//   CHK_BYTES   : trailing checksum bytes per frame (1 when CHECKSUM_EN is defined, else 0)
//   FRAME_BYTES : total bytes per frame
//   byte_time() : clock cycles per UART byte (start + 8 data + stop bits)
//   xor_bytes() : XOR of the four bytes of a word (CHECKSUM_EN builds only)
// Build option: define CHECKSUM_EN to expect a fifth, XOR checksum byte per word.
package uart_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

  localparam int WORD_BYTES = 4;

`ifdef CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  localparam int FRAME_BYTES = WORD_BYTES + CHK_BYTES;

  // One byte on the wire is 10 bit times.
  function automatic int unsigned byte_time(input int unsigned clk_fre,
                                            input int unsigned baud_rate);
    return (clk_fre / baud_rate) * 10;
  endfunction

`ifdef CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
`endif

endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt
// Loadable 32-bit down-counter used as the inter-byte silence timer.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous, active-low reset
//   clr      in   synchronous clear (highest synchronous priority)
//   load     in   reload count with load_val (every received byte)
//   load_val in   reload value (timeout limit minus one)
//   run      in   count down while high (a partial word is pending)
//   expire   out  high while running with the count at zero
module uart_timeout_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        run,
  output logic        expire
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (run && (count_q != '0)) begin
      count_q <= count_q - 32'd1;
    end
  end

  // A load in the expiring cycle still lets the expire through: the
  // partial word is dropped and the new byte starts a fresh word.
  assign expire = run && (count_q == '0);

endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer
// Packs bytes from the UART receiver into 32-bit words for the FIR core,
// with an inter-byte timeout and a one-word output holding register.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   clr         in   synchronous clear, same effect as reset
//   rx_valid    in   one-cycle byte strobe
//   rx_data     in   received byte
//   word_valid  out  output register holds an untransferred word
//   word_ready  in   consumer accepts the word
//   word_data   out  assembled word, stable while word_valid=1
//   byte_cnt    out  bytes held in the partial word
//   busy        out  partial word pending or word held
//   timeout_err out  one-cycle pulse when a partial word times out
//   overrun_err out  sticky: a completed word was dropped
//   chk_err     out  one-cycle pulse on checksum mismatch (0 without CHECKSUM_EN)
// Handshake: a word transfers on a rising edge where word_valid && word_ready;
// word_valid only falls on a transfer, and word_ready is ignored while
// word_valid=0.
// Build option: CHECKSUM_EN adds a trailing XOR checksum byte per word.
module uart_word_packer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE       = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter bit          MSB_FIRST     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [2:0]  byte_cnt,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic        chk_err
);

  localparam logic [31:0] TIMEOUT_LIMIT =
    32'(TIMEOUT_BYTES * byte_time(CLK_FRE, BAUD_RATE) - 1);
  localparam logic [2:0]  LAST_CNT = 3'(FRAME_BYTES - 1);

  asm_state_t  state_q, state_d, cur_state;
  logic [2:0]  byte_cnt_q, cnt_d, cur_cnt;
  logic [31:0] asm_q, asm_d, cur_asm, shifted;
  logic [31:0] word_q, done_word;
  logic        word_valid_q, overrun_q, timeout_err_q;
  logic        word_done, expire, transfer;

  uart_timeout_cnt u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (rx_valid),
    .load_val (TIMEOUT_LIMIT),
    .run      (byte_cnt_q != 3'd0),
    .expire   (expire)
  );

  assign transfer = word_valid_q && word_ready;

`ifdef CHECKSUM_EN
  logic chk_bad, chk_err_q;
`endif

  // Assembly FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 3'd0;
      asm_q      <= '0;
    end else if (clr) begin
      state_q    <= IDLE;
      byte_cnt_q <= 3'd0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= cnt_d;
      asm_q      <= asm_d;
    end
  end

  // Assembly FSM: next state. A timeout first wipes the partial word so a
  // byte arriving in the same cycle is treated as the first of a new word.
  always_comb begin
    cur_state = expire ? IDLE : state_q;
    cur_cnt   = expire ? 3'd0 : byte_cnt_q;
    cur_asm   = expire ? 32'd0 : asm_q;
    shifted   = MSB_FIRST ? {cur_asm[23:0], rx_data} : {rx_data, cur_asm[31:8]};
    state_d   = cur_state;
    cnt_d     = cur_cnt;
    asm_d     = cur_asm;
    word_done = 1'b0;
`ifdef CHECKSUM_EN
    done_word = cur_asm;
    chk_bad   = 1'b0;
`else
    done_word = shifted;
`endif
    if (rx_valid) begin
      case (cur_state)
        IDLE: begin
          state_d = COLLECT;
          cnt_d   = 3'd1;
          asm_d   = shifted;
        end
        COLLECT: begin
          if (cur_cnt == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            asm_d   = '0;
`ifdef CHECKSUM_EN
            // Final byte is the checksum; it is compared, not shifted in.
            if (rx_data == xor_bytes(cur_asm)) word_done = 1'b1;
            else                               chk_bad   = 1'b1;
`else
            word_done = 1'b1;
`endif
          end else begin
            cnt_d = 3'(cur_cnt + 3'd1);
            asm_d = shifted;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          asm_d   = '0;
        end
      endcase
    end
  end

  // Output holding register and error flags. A completing word may load
  // into a full register only when the held word leaves in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else if (clr) begin
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= expire;
      if (word_done && (!word_valid_q || transfer)) begin
        word_q       <= done_word;
        word_valid_q <= 1'b1;
      end else if (transfer) begin
        word_valid_q <= 1'b0;
      end
      if (word_done && word_valid_q && !transfer) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     chk_err_q <= 1'b0;
    else if (clr) chk_err_q <= 1'b0;
    else          chk_err_q <= chk_bad;
  end
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign word_valid  = word_valid_q;
  assign word_data   = word_q;
  assign byte_cnt    = byte_cnt_q;
  assign busy        = (byte_cnt_q != 3'd0) || word_valid_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer
// Directed bench for uart_word_packer. Two instances share the inputs:
// dut (MSB_FIRST=1) and dut_l (MSB_FIRST=0, expected word byte-swapped).
// Honours CHECKSUM_EN: frames then carry a fifth XOR byte.
module tb_uart_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        word_ready = 1'b0;

  logic        word_valid, busy, timeout_err, overrun_err, chk_err;
  logic [31:0] word_data;
  logic [2:0]  byte_cnt;

  logic        word_valid_l, busy_l, timeout_err_l, overrun_err_l, chk_err_l;
  logic [31:0] word_data_l;
  logic [2:0]  byte_cnt_l;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // clock / reset
  always #5 clk = ~clk;

  uart_word_packer dut (
    .clk(clk), .rst(rst), .clr(clr), .rx_valid(rx_valid), .rx_data(rx_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .byte_cnt(byte_cnt), .busy(busy), .timeout_err(timeout_err),
    .overrun_err(overrun_err), .chk_err(chk_err)
  );

  uart_word_packer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .rx_valid(rx_valid), .rx_data(rx_data),
    .word_valid(word_valid_l), .word_ready(word_ready), .word_data(word_data_l),
    .byte_cnt(byte_cnt_l), .busy(busy_l), .timeout_err(timeout_err_l),
    .overrun_err(overrun_err_l), .chk_err(chk_err_l)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic check_word(input string tag, input logic [31:0] w);
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
    check({tag, "_data"}, word_data, w);
    check({tag, "_data_lsb"}, word_data_l, swap(w));
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends bytes from index 'from' of word w (first byte = w[31:24]), then
  // the checksum byte when enabled; optionally raises word_ready on the last strobe.
  task automatic send_frame(input logic [31:0] w, input int from, input bit ready_last);
    logic [7:0] frame [5];
    int n;
    for (int i = 0; i < 4; i++) frame[i] = w[31-8*i -: 8];
    frame[4] = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`ifdef CHECKSUM_EN
    n = 5;
`else
    n = 4;
`endif
    for (int i = from; i < n; i++) begin
      if (ready_last && (i == n - 1)) word_ready = 1'b1;
      send_byte(frame[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_data"}, word_data, 32'd0);
    check({tag, "_cnt"}, 32'(byte_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    check({tag, "_ovr"}, 32'(overrun_err), 32'd0);
    check({tag, "_chk"}, 32'(chk_err), 32'd0);
  endtask

  initial begin
    // reset
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // 1: 0x3F800000 with consumer ready; valid for exactly one cycle
    word_ready = 1'b1;
    send_byte(8'h3F);
    send_byte(8'h80);
    send_byte(8'h00);
    check("t1_cnt3", 32'(byte_cnt), 32'd3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_novalid", 32'(word_valid), 32'd0);
`ifdef CHECKSUM_EN
    send_byte(8'h00);
    check("t1_cnt4", 32'(byte_cnt), 32'd4);
    check("t1_novalid4", 32'(word_valid), 32'd0);
    send_frame(32'h3F800000, 4, 1'b0);
`else
    send_frame(32'h3F800000, 3, 1'b0);
`endif
    check_word("t1", 32'h3F800000);
    check("t1_cnt0", 32'(byte_cnt), 32'd0);
    check("t1_chk", 32'(chk_err), 32'd0);
    tick();
    check("t1_drop", 32'(word_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: back-pressure, second word dropped
    word_ready = 1'b0;
    send_frame(32'h40490FDB, 0, 1'b0);
    check_word("t2a", 32'h40490FDB);
    check("t2_ovr0", 32'(overrun_err), 32'd0);
    send_frame(32'h3F000000, 0, 1'b0);
    check("t2_ovr1", 32'(overrun_err), 32'd1);
    check_word("t2_held", 32'h40490FDB);
    tick();
    check("t2_stillvalid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    tick();
    check("t2_xfer", 32'(word_valid), 32'd0);
    check("t2_sticky", 32'(overrun_err), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_all_zero("t2_clr");

    // 3: timeout after two bytes, boundary cycle checked
    send_byte(8'h12);
    send_byte(8'h34);
    check("t3_cnt2", 32'(byte_cnt), 32'd2);
    repeat (17359) tick();
    check("t3_early_cnt", 32'(byte_cnt), 32'd2);
    check("t3_early_tmo", 32'(timeout_err), 32'd0);
    tick();
    check("t3_cnt0", 32'(byte_cnt), 32'd0);
    check("t3_tmo", 32'(timeout_err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    tick();
    check("t3_tmo_pulse", 32'(timeout_err), 32'd0);
    send_frame(32'hC0000000, 0, 1'b0);
    check_word("t3", 32'hC0000000);
    check("t3_ovr", 32'(overrun_err), 32'd0);
    tick();

    // 3b: byte arriving in the timeout cycle starts a new word
    send_byte(8'hAA);
    repeat (17359) tick();
    send_byte(8'hBB);
    check("t3b_cnt1", 32'(byte_cnt), 32'd1);
    check("t3b_tmo", 32'(timeout_err), 32'd1);
    send_frame(32'hBB010203, 1, 1'b0);
    check_word("t3b", 32'hBB010203);
    tick();

    // 4: held word leaves as the next word completes
    word_ready = 1'b0;
    send_frame(32'h42280000, 0, 1'b0);
    check_word("t4a", 32'h42280000);
    send_frame(32'h41200000, 0, 1'b1);
    check_word("t4b", 32'h41200000);
    check("t4_ovr", 32'(overrun_err), 32'd0);
    tick();
    check("t4_xfer", 32'(word_valid), 32'd0);

    // 5: asynchronous reset mid-word
    word_ready = 1'b0;
    send_frame(32'hDEADBEEF, 0, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("t5_cnt3", 32'(byte_cnt), 32'd3);
    rst = 1'b0;
    #1;
    check_all_zero("t5_rst");
    tick();
    rst = 1'b1;
    tick();
    word_ready = 1'b1;
    send_frame(32'h11223344, 0, 1'b0);
    check_word("t5", 32'h11223344);
    tick();

`ifdef CHECKSUM_EN
    // 6: checksum good and bad
    send_byte(8'h3F);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t6_cnt4", 32'(byte_cnt), 32'd4);
    send_byte(8'hBF);
    check_word("t6_good", 32'h3F800000);
    check("t6_chk0", 32'(chk_err), 32'd0);
    tick();
    send_byte(8'h3F);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t6_chk1", 32'(chk_err), 32'd1);
    check("t6_novalid", 32'(word_valid), 32'd0);
    check("t6_cnt0", 32'(byte_cnt), 32'd0);
    tick();
    check("t6_chk_pulse", 32'(chk_err), 32'd0);
`else
    check("t6_chk_tied", 32'(chk_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
